// File: rtl/pipe_frontend_buffered_pkg.sv
// Shared pipe defines: spec-word decoding, bundle field positions and
// buffer sizing helpers used by the pipe front end and its storage.
package pipe_frontend_buffered_pkg;

  // Spec word: low byte is the data width, PS_START_STOP flags start/stop fields.
  localparam int unsigned PS_DATA_MASK  = 32'h0000_00FF;
  localparam int unsigned PS_START_STOP = 32'h0000_0100;

  // Legal buffer depths.
  localparam int unsigned P_DEPTH_MIN = 1;
  localparam int unsigned P_DEPTH_MAX = 32;

  // Bundle layout, LSB first: data, [start, stop], valid, ready.
  function automatic int unsigned P_Data_w(input int unsigned spec);
    return spec & PS_DATA_MASK;
  endfunction

  function automatic bit P_Has_ss(input int unsigned spec);
    return (spec & PS_START_STOP) != 0;
  endfunction

  function automatic int unsigned P_Start_b(input int unsigned spec);
    return P_Data_w(spec);
  endfunction

  function automatic int unsigned P_Stop_b(input int unsigned spec);
    return P_Data_w(spec) + 1;
  endfunction

  function automatic int unsigned P_Valid_b(input int unsigned spec);
    return P_Data_w(spec) + (P_Has_ss(spec) ? 2 : 0);
  endfunction

  function automatic int unsigned P_Ready_b(input int unsigned spec);
    return P_Valid_b(spec) + 1;
  endfunction

  function automatic int unsigned P_w(input int unsigned spec);
    return P_Ready_b(spec) + 1;
  endfunction

  // Occupancy counter must hold 0..depth inclusive.
  function automatic int unsigned P_Cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer addresses 0..depth-1; a single-entry buffer still needs one bit.
  function automatic int unsigned P_Ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buffer_ram.sv
// Register-array storage for the front-end buffer: one synchronous write
// port and one asynchronous read port. Contents have no reset; validity is
// tracked by the occupancy count in the parent.
module pipe_buffer_ram #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 10,
  parameter int unsigned AddrW = 1
) (
  input  logic             clock,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr,
  output logic [Width-1:0] o_rdata
);

  logic [Width-1:0] r_mem [Depth];

  // Write the addressed entry when enabled.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_frontend_buffered.sv
// Pipe front end: unpacks the packed pipe bundle into start/stop/data/valid
// for the consumer, behind a circular elastic buffer of Depth entries with an
// optional combinational fall-through when empty.
//
// Handshake: a word moves on a clock edge exactly when its valid and ready
// are both high at that edge. Upstream ready depends only on registered
// occupancy and reset, never on in_ready; in_valid never depends on in_ready.
module pipe_frontend_buffered
  import pipe_frontend_buffered_pkg::*;
#(
  parameter int unsigned PipeSpec    = 8 | PS_START_STOP,
  parameter int unsigned Depth       = 2,
  parameter bit          FallThrough = 1'b1
) (
  input  logic                          clock,
  input  logic                          reset,
  inout  logic [P_w(PipeSpec)-1:0]      pipe_in,
  output logic                          in_start,
  output logic                          in_stop,
  output logic [P_Data_w(PipeSpec)-1:0] in_data,
  output logic                          in_valid,
  input  logic                          in_ready,
  output logic [P_Cnt_w(Depth)-1:0]     in_count
);

  localparam int unsigned DW = P_Data_w(PipeSpec);
  localparam int unsigned EW = DW + 2;
  localparam int unsigned CW = P_Cnt_w(Depth);
  localparam int unsigned PW = P_Ptr_w(Depth);
  localparam int unsigned VB = P_Valid_b(PipeSpec);
  localparam int unsigned RB = P_Ready_b(PipeSpec);

  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_wp_next, w_rp_next;
  logic [CW-1:0] w_count_next;

  logic          w_p_valid, w_p_start, w_p_stop;
  logic [DW-1:0] w_p_data;
  logic [EW-1:0] w_wr_entry, w_rd_entry;
  logic          w_empty, w_full, w_ready, w_accept, w_deliver;
  logic          w_bypass, w_write, w_pop;

  // Field extraction from the incoming bundle.
  assign w_p_data  = pipe_in[DW-1:0];
  assign w_p_valid = pipe_in[VB];
  if (P_Has_ss(PipeSpec)) begin : g_ss
    assign w_p_start = pipe_in[P_Start_b(PipeSpec)];
    assign w_p_stop  = pipe_in[P_Stop_b(PipeSpec)];
  end else begin : g_no_ss
    assign w_p_start = 1'b0;
    assign w_p_stop  = 1'b0;
  end

  // Ready goes back onto the bundle; held low throughout reset.
  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CW'(Depth));
  assign w_ready       = !w_full && !reset;
  assign pipe_in[RB]   = w_ready;

  assign w_accept   = w_p_valid && w_ready;
  assign w_bypass   = FallThrough && w_empty;
  assign w_deliver  = in_valid && in_ready;
  // A bypassed word that is taken straight away never touches storage.
  assign w_write    = w_accept && !(w_bypass && w_deliver);
  assign w_pop      = w_deliver && !w_bypass;
  assign w_wr_entry = {w_p_start, w_p_stop, w_p_data};
  assign in_count   = reset ? '0 : r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  pipe_buffer_ram #(
    .Depth (Depth),
    .Width (EW),
    .AddrW (PW)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_write),
    .i_waddr (r_wp),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rp),
    .o_rdata (w_rd_entry)
  );

  // Present either the live pipe word (bypass) or the oldest stored entry.
  always_comb begin
    {in_start, in_stop, in_data} = w_rd_entry;
    in_valid = 1'b0;
    if (w_bypass) begin
      {in_start, in_stop, in_data} = w_wr_entry;
      in_valid = w_p_valid && !reset;
    end else begin
      in_valid = !w_empty && !reset;
    end
  end

  // Next pointer and occupancy values.
  always_comb begin
    w_wp_next    = r_wp;
    w_rp_next    = r_rp;
    w_count_next = r_count + CW'(w_write) - CW'(w_pop);
    if (w_write) w_wp_next = ptr_inc(r_wp);
    if (w_pop)   w_rp_next = ptr_inc(r_rp);
  end

  // Pointer and occupancy state; reset discards all buffered words.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= w_wp_next;
      r_rp    <= w_rp_next;
      r_count <= w_count_next;
    end
  end

endmodule
